// File: rtl/signed_mult_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// signed_mult_arb_pkg : shared types and defaults for the multiplier arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
package signed_mult_arb_pkg;

  localparam int c_A_W_DEF = 15;
  localparam int c_B_W_DEF = 9;
  localparam int c_P_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // A single requester still needs a one-bit id.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin one-hot grant, priority starts after last winner
// Revision 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    ptr_d   = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
    if (gnt_any) begin
      ptr_d = gnt_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= c_PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/signed_mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// signed_mult_arbiter : shares one pipelined signed multiplier among requesters
// Revision 1.0
// ----------------------------------------------------------------------------
module signed_mult_arbiter
  import signed_mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_W      = c_A_W_DEF,
  parameter int B_W      = c_B_W_DEF,
  parameter int P_W      = c_P_W_DEF,
  parameter int MULT_LAT = 2,
  parameter int ID_W     = id_width(NUM_REQ),
  parameter int CNT_W    = $clog2(MULT_LAT + 2)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic                   pause,
  output logic                   idle,
  output logic [A_W-1:0]         mult_dataa,
  output logic [B_W-1:0]         mult_datab,
  input  logic [P_W-1:0]         mult_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       in_flight
);

  state_e            state_q, state_d;
  logic [A_W-1:0]    dataa_q, dataa_d;
  logic [B_W-1:0]    datab_q, datab_d;
  logic [MULT_LAT:0] vld_q, vld_d;
  logic [ID_W-1:0]   tag_q [MULT_LAT+1];
  logic [ID_W-1:0]   tag_d [MULT_LAT+1];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              w_gnt_en;
  logic              w_gnt_any;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_retire;

  assign w_gnt_en = (state_q == ST_RUN) && !pause && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .en      (w_gnt_en),
    .gnt     (gnt),
    .gnt_id  (w_gnt_id),
    .gnt_any (w_gnt_any)
  );

  assign w_retire = vld_q[MULT_LAT];

  // Operands are only loaded on a grant so the multiplier input stays quiet otherwise.
  always_comb begin
    dataa_d = dataa_q;
    datab_d = datab_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        dataa_d = req_a[i*A_W +: A_W];
        datab_d = req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    vld_d    = {vld_q[MULT_LAT-1:0], w_gnt_any};
    tag_d[0] = w_gnt_id;
    for (int k = 1; k <= MULT_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({w_gnt_any, w_retire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Next count is used so idle rises the cycle right after the last response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (pause) begin
          state_d = (cnt_d == '0) ? ST_PAUSED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pause) begin
          state_d = ST_RUN;
        end else if (cnt_d == '0) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      dataa_q <= '0;
      datab_q <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k <= MULT_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      dataa_q <= dataa_d;
      datab_q <= datab_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k <= MULT_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (w_retire) begin
      rsp_valid[tag_q[MULT_LAT]] = 1'b1;
    end
  end

  assign rsp_id     = tag_q[MULT_LAT];
  assign rsp_data   = mult_result;
  assign mult_dataa = dataa_q;
  assign mult_datab = datab_q;
  assign in_flight  = cnt_q;
  assign idle       = (state_q == ST_PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_signed_mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_signed_mult_arbiter : randomized scoreboard bench for signed_mult_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_signed_mult_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int A_W      = 15;
  localparam int B_W      = 9;
  localparam int P_W      = 24;
  localparam int MULT_LAT = 2;
  localparam int ID_W     = 2;
  localparam int CNT_W    = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     gnt;
  logic                   pause;
  logic                   idle;
  logic [A_W-1:0]         mult_dataa;
  logic [B_W-1:0]         mult_datab;
  logic [P_W-1:0]         mult_result;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [P_W-1:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       in_flight;

  always #5 clock = ~clock;

  signed_mult_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .A_W      (A_W),
    .B_W      (B_W),
    .P_W      (P_W),
    .MULT_LAT (MULT_LAT),
    .ID_W     (ID_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .pause       (pause),
    .idle        (idle),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_result (mult_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .in_flight   (in_flight)
  );

  // External multiplier: MULT_LAT registers after the operand registers.
  logic signed [P_W-1:0] mpipe [MULT_LAT];
  always @(posedge clock) begin
    mpipe[0] <= $signed(mult_dataa) * $signed(mult_datab);
    for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_result = mpipe[MULT_LAT-1];

  typedef struct {
    int             id;
    logic [P_W-1:0] data;
    int             due;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: last winner, grant window open/closed, idle flag,
  // and a history of which of the last MULT_LAT+1 cycles issued.
  int m_last = NUM_REQ - 1;
  bit m_run  = 1'b1;
  bit m_idle = 1'b0;
  bit sh [MULT_LAT+1];

  always @(negedge clock) begin
    logic [NUM_REQ-1:0]    eg;
    logic signed [A_W-1:0] a_sel;
    logic signed [B_W-1:0] b_sel;
    int gid, infl, nxt, idx, prod;
    eg   = '0;
    gid  = -1;
    infl = 0;
    if (reset) begin
      chk("gnt_in_reset", gnt, 0);
      m_last = NUM_REQ - 1;
      m_run  = 1'b1;
      m_idle = 1'b0;
      for (int k = 0; k <= MULT_LAT; k++) sh[k] = 1'b0;
      sbq.delete();
    end else begin
      for (int k = 0; k <= MULT_LAT; k++) infl += int'(sh[k]);
      chk("in_flight", in_flight, infl);
      chk("idle", idle, m_idle);
      if (m_run && !pause) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          idx = (m_last + i) % NUM_REQ;
          if (gid < 0 && req[idx]) gid = idx;
        end
      end
      if (gid >= 0) begin
        eg[gid] = 1'b1;
        a_sel   = req_a[gid*A_W +: A_W];
        b_sel   = req_b[gid*B_W +: B_W];
        prod    = int'(a_sel) * int'(b_sel);
        sbq.push_back('{id: gid, data: prod[P_W-1:0], due: cyc + MULT_LAT + 1});
        m_last  = gid;
      end
      chk("gnt", gnt, eg);
      nxt = infl + ((gid >= 0) ? 1 : 0) - (sh[MULT_LAT] ? 1 : 0);
      for (int k = MULT_LAT; k > 0; k--) sh[k] = sh[k-1];
      sh[0] = (gid >= 0);
      if (m_run) begin
        if (pause) begin
          m_run  = 1'b0;
          m_idle = (nxt == 0);
        end
      end else if (!pause) begin
        m_run  = 1'b1;
        m_idle = 1'b0;
      end else if (nxt == 0) begin
        m_idle = 1'b1;
      end
    end
  end

  // Monitor: every presented response must match the oldest outstanding one.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid %0h, expected none", cyc, rsp_valid);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", rsp_valid, 32'(1) << e.id);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_rsp at cycle %0d: got no response, expected id %0d due %0d", cyc, e.id, e.due);
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*A_W +: A_W] = A_W'($urandom);
      req_b[i*B_W +: B_W] = B_W'($urandom);
    end
  endtask

  task automatic step(input logic [NUM_REQ-1:0] r, input logic p);
    req   = r;
    pause = p;
    @(posedge clock);
    #1;
  endtask

  logic pz;

  initial begin
    req   = '0;
    pause = 1'b0;
    req_a = '0;
    req_b = '0;
    pz    = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single request on lane 2: -3 * 5
    rand_ops();
    req_a[2*A_W +: A_W] = 15'h7FFD;
    req_b[2*B_W +: B_W] = 9'h005;
    step(4'b0100, 1'b0);
    repeat (4) begin rand_ops(); step('0, 1'b0); end

    // Operand extremes
    req_a[0 +: A_W] = 15'h4000;
    req_b[0 +: B_W] = 9'h100;
    step(4'b0001, 1'b0);
    req_a[0 +: A_W] = 15'h3FFF;
    req_b[0 +: B_W] = 9'h1FF;
    step(4'b0001, 1'b0);
    repeat (4) step('0, 1'b0);

    // Fresh pointer, all four held for 8 cycles, then pause with 3 in flight
    reset = 1'b1;
    step('0, 1'b0);
    reset = 1'b0;
    repeat (8) begin rand_ops(); step(4'hF, 1'b0); end
    repeat (6) step(4'hF, 1'b1);
    repeat (3) begin rand_ops(); step(4'hF, 1'b0); end
    repeat (5) step('0, 1'b0);

    // Reset right after two grants
    repeat (2) begin rand_ops(); step(4'hF, 1'b0); end
    reset = 1'b1;
    step(4'hF, 1'b0);
    reset = 1'b0;
    repeat (2) begin rand_ops(); step(4'hF, 1'b0); end
    repeat (5) step('0, 1'b0);

    // Pause dropped during drain
    repeat (3) begin rand_ops(); step(4'hF, 1'b0); end
    step(4'hF, 1'b1);
    repeat (3) begin rand_ops(); step(4'hF, 1'b0); end
    repeat (5) step('0, 1'b0);

    // Random traffic with pause bursts and rare resets
    for (int n = 0; n < 3000; n++) begin
      rand_ops();
      if ($urandom_range(0, 15) == 0) pz = ~pz;
      reset = ($urandom_range(0, 399) == 0);
      step(NUM_REQ'($urandom), pz);
    end
    reset = 1'b0;
    repeat (10) step('0, 1'b0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signed_mult_arbiter.md
Name: signed_mult_arbiter

Overview:
- Shares one registered signed multiplier (15x9 -> 24 bits, fixed MULT_LAT latency, no enable/stall) among NUM_REQ requesters in the Reed-Solomon datapath.
- Uses round-robin arbitration and issues at most one operand pair per cycle.
- Tracks each in-flight product with a requester tag and returns the result to the originating requester.
- Provides pause/drain control so syndrome/Chien stages can quiesce the multiplier before reconfiguration.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- A_W, 15: signed width of operand A.
- B_W, 9: signed width of operand B.
- P_W, 24: signed product width; must equal A_W+B_W.
- MULT_LAT, 2: multiplier clock cycles from operands-at-input to result-at-output (>=1).
- ID_W, 2: requester id width, equal to clog2(NUM_REQ).

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester request, level
- req_a  in  NUM_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed operand B
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted request
- pause  in  1  stop issuing new grants
- idle  out  1  paused and pipeline empty
- mult_dataa  out  A_W  registered operand to multiplier dataa
- mult_datab  out  B_W  registered operand to multiplier datab
- mult_result  in  P_W  multiplier result
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_data  out  P_W  product, equals mult_result
- rsp_id  out  ID_W  requester index of the current response
- in_flight  out  clog2(MULT_LAT+2)  count of issued, not yet returned operations

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. While reset is high, gnt is 0.
- Reset values: rsp_valid=0, rsp_id=0, in_flight=0, mult_dataa=0, mult_datab=0, idle=0, state=RUN, RR pointer=NUM_REQ-1, so req[0] has first priority.
- Arbitration:
  - A grant is issued only in RUN with pause low.
  - Priority starts at pointer+1 modulo NUM_REQ.
  - On a grant, the pointer is set to the granted index.
  - Requesters sample gnt and treat the request as consumed that cycle.
- Issue:
  - A grant in cycle t captures the operands into mult_dataa/b and sets valid/tag pipe stage 0 at the end of cycle t.
  - With no grant, the operand registers hold their value and stage-0 valid is 0.
- Return:
  - The valid/tag pipe has MULT_LAT+1 stages.
  - Stage MULT_LAT drives rsp_valid[tag], rsp_id and rsp_data=mult_result.
  - A response is presented in cycle t+1+MULT_LAT, i.e. grant-to-response latency is MULT_LAT+1 cycles.
  - There is no backpressure; responses are single-cycle strobes.
- Throughput: one grant per cycle sustained. Results return in issue order.
- in_flight: +1 on grant, -1 on response, unchanged when both occur in the same cycle. Never exceeds MULT_LAT+1.
- FSM:
  - RUN -> DRAIN when pause rises.
  - DRAIN -> PAUSED when in_flight==0, or immediately if already 0.
  - PAUSED -> RUN when pause is low.
  - DRAIN -> RUN if pause drops before the pipeline empties.
  - idle=1 only in PAUSED.
  - In DRAIN and PAUSED, gnt=0 and responses still retire.
- Simultaneous events:
  - pause high in a cycle with pending requests: no grant that cycle.
  - A requester deasserting req without a grant is legal.
  - A single requester held continuously is granted every cycle.
- Reset mid-operation: all pipe valids clear; in-flight products are discarded and no rsp_valid follows.
- Arithmetic: full two's-complement product; no truncation or saturation inside this block.

Decomposition:
- Package signed_mult_arb_pkg holds:
  - A_W/B_W/P_W defaults;
  - FSM state encoding (RUN, DRAIN, PAUSED, 2 bits);
  - an id-width helper function.
- Sub-module rr_arbiter(NUM_REQ) holds the round-robin pointer and produces the one-hot grant from req, enable and pointer. It is reusable by other shared GF/multiplier resources.
- The top level holds the operand registers, tag pipe, in_flight counter and FSM.

Test Plan:
- Single request: req[2], a=15'h7FFD (-3), b=9'h005, cycle t -> gnt=4'b0100 in t; rsp_valid=4'b0100, rsp_id=2, rsp_data=24'hFFFFF1 (-15) in t+3.
- All four requesters held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses follow in the same order 3 cycles after each grant, with in_flight saturating at 3.
- Extremes: a=15'h4000 (-16384), b=9'h100 (-256) -> rsp_data=24'h400000 (+4194304). Also a=15'h3FFF, b=9'h1FF (-1) -> 24'hFFC001.
- Pause with 3 in flight -> gnt=0 immediately; idle rises one cycle after the last response. Deassert pause -> the next grant goes to pointer+1.
- Reset asserted one cycle after 2 grants -> no rsp_valid ever appears for them; in_flight=0 and the pointer is back at NUM_REQ-1.
- Pause toggled low during DRAIN -> return to RUN, grants resume the next cycle, and no in-flight result is lost.
